rate_counter_gen: RTL and testbench

- Parametrised successor to the board's fixed 4-bit rate-divided display counter.
- One shared down-counting rate divider selects one of NUM_RATES reload values and produces a step tick.
- The tick advances a WIDTH-bit counter that supports:
  - up/down direction
  - wrap or saturate at a programmable modulus
  - parallel load and synchronous clear
- Sits between board switches and hex_display; tick and tc are exported so instances can cascade into multi-digit counters.

---
 rtl/rate_counter_gen_pkg.sv | 28 ++
 rtl/rate_counter_gen_tick.sv | 69 ++++++
 rtl/rate_counter_gen.sv | 101 ++++++++++
 tb/tb_rate_counter_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rate_counter_gen_pkg.sv
// ============================================================================
// Module      : rate_counter_gen_pkg
// Description : Board reload constants and counter operation encoding shared
//               by the rate divider and the counter datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rate_counter_gen_pkg;

    localparam int c_DIV_W = 28;

    // Reload values for a 50 MHz board clock; tick period is reload + 1.
    localparam logic [c_DIV_W-1:0] c_RATE_1HZ    = 28'd49_999_999;
    localparam logic [c_DIV_W-1:0] c_RATE_0P5HZ  = 28'd99_999_999;
    localparam logic [c_DIV_W-1:0] c_RATE_0P25HZ = 28'd199_999_999;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_CLEAR = 3'd1,
        OP_LOAD  = 3'd2,
        OP_INC   = 3'd3,
        OP_DEC   = 3'd4
    } cnt_op_e;

endpackage

`default_nettype wire

// File: rtl/rate_counter_gen_tick.sv
// ============================================================================
// Module      : tick_gen
// Description : Shared down-counting rate divider with selectable reload.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int                           DIV_W     = rate_counter_gen_pkg::c_DIV_W,
    parameter int                           NUM_RATES = 4,
    parameter int                           SEL_W     = 2,
    parameter logic [NUM_RATES*DIV_W-1:0]   RATES     = {
        rate_counter_gen_pkg::c_RATE_0P25HZ,
        rate_counter_gen_pkg::c_RATE_0P5HZ,
        rate_counter_gen_pkg::c_RATE_1HZ,
        28'd0
    }
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             run,
    input  logic [SEL_W-1:0] sel,
    input  logic             clear_b,
    output logic             tick
);

    localparam int c_NUM_SEL = 2**SEL_W;

    logic [DIV_W-1:0] w_table [c_NUM_SEL];
    logic [DIV_W-1:0] w_reload;
    logic [DIV_W-1:0] r_div_cnt;
    logic [SEL_W-1:0] r_sel_q;
    logic             w_sel_same;

    // Selects beyond the table fall back to a reload of zero.
    for (genvar i = 0; i < c_NUM_SEL; i++) begin : g_table
        if (i < NUM_RATES) begin : g_rate
            assign w_table[i] = RATES[i*DIV_W +: DIV_W];
        end else begin : g_zero
            assign w_table[i] = '0;
        end
    end

    assign w_reload   = w_table[sel];
    assign w_sel_same = (sel == r_sel_q);
    assign tick       = run && (r_div_cnt == '0) && w_sel_same;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_div_cnt <= '0;
            r_sel_q   <= '0;
        end else if (!w_sel_same) begin
            // Restart the period on a rate change so no short tick escapes.
            r_div_cnt <= w_reload;
            r_sel_q   <= sel;
        end else if (!clear_b) begin
            r_div_cnt <= w_reload;
        end else if (run) begin
            if (r_div_cnt == '0) begin
                r_div_cnt <= w_reload;
            end else begin
                r_div_cnt <= r_div_cnt - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rate_counter_gen.sv
// ============================================================================
// Module      : rate_counter_gen
// Description : Rate-divided up/down counter with wrap/saturate, load, clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rate_counter_gen #(
    parameter int                           WIDTH     = 4,
    parameter int                           DIV_W     = rate_counter_gen_pkg::c_DIV_W,
    parameter int                           NUM_RATES = 4,
    parameter int                           SEL_W     = 2,
    parameter logic [NUM_RATES*DIV_W-1:0]   RATES     = {
        rate_counter_gen_pkg::c_RATE_0P25HZ,
        rate_counter_gen_pkg::c_RATE_0P5HZ,
        rate_counter_gen_pkg::c_RATE_1HZ,
        28'd0
    },
    parameter int                           MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             run,
    input  logic [SEL_W-1:0] sel,
    input  logic             clear_b,
    input  logic             parload,
    input  logic [WIDTH-1:0] d,
    input  logic             up,
    input  logic             wrap,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc,
    output logic             at_limit
);

    import rate_counter_gen_pkg::*;

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_load_val;
    cnt_op_e          w_op;

    tick_gen #(
        .DIV_W     (DIV_W),
        .NUM_RATES (NUM_RATES),
        .SEL_W     (SEL_W),
        .RATES     (RATES)
    ) u_tick_gen (
        .clk     (clk),
        .reset_b (reset_b),
        .run     (run),
        .sel     (sel),
        .clear_b (clear_b),
        .tick    (tick)
    );

    assign at_limit   = up ? (r_q == c_MAX) : (r_q == '0);
    assign w_load_val = (d > c_MAX) ? c_MAX : d;

    always_comb begin
        w_op = OP_HOLD;
        if (!clear_b) begin
            w_op = OP_CLEAR;
        end else if (parload) begin
            w_op = OP_LOAD;
        end else if (tick) begin
            w_op = up ? OP_INC : OP_DEC;
        end
    end

    always_comb begin
        w_q_next = r_q;
        case (w_op)
            OP_CLEAR: w_q_next = '0;
            OP_LOAD:  w_q_next = w_load_val;
            OP_INC:   w_q_next = (r_q == c_MAX) ? (wrap ? '0 : c_MAX) : r_q + 1'b1;
            OP_DEC:   w_q_next = (r_q == '0) ? (wrap ? c_MAX : '0) : r_q - 1'b1;
            default:  w_q_next = r_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_q  <= '0;
            r_tc <= 1'b0;
        end else begin
            r_q  <= w_q_next;
            // Flags a step taken at the limit, whether it wrapped or saturated.
            r_tc <= tick && at_limit && clear_b && !parload;
        end
    end

    assign q  = r_q;
    assign tc = r_tc;

endmodule

`default_nettype wire

// File: tb/tb_rate_counter_gen.sv
// ============================================================================
// Module      : tb_rate_counter_gen
// Description : Scoreboard bench for rate_counter_gen with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rate_counter_gen;

    localparam int c_WIDTH = 4;
    localparam int c_DIV_W = 28;

    logic               clk = 1'b0;
    logic               reset_b;
    logic               run;
    logic [1:0]         sel;
    logic               clear_b;
    logic               parload;
    logic [c_WIDTH-1:0] d;
    logic               up;
    logic               wrap;
    logic [c_WIDTH-1:0] q;
    logic               tick;
    logic               tc;
    logic               at_limit;

    typedef struct {
        logic [c_WIDTH-1:0] q;
        logic               tick;
        logic               tc;
        string              name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event mid_ev;

    rate_counter_gen #(
        .WIDTH     (c_WIDTH),
        .DIV_W     (c_DIV_W),
        .NUM_RATES (4),
        .SEL_W     (2),
        .RATES     ({28'd3, 28'd2, 28'd1, 28'd0}),
        .MAX_COUNT (9)
    ) dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .run      (run),
        .sel      (sel),
        .clear_b  (clear_b),
        .parload  (parload),
        .d        (d),
        .up       (up),
        .wrap     (wrap),
        .q        (q),
        .tick     (tick),
        .tc       (tc),
        .at_limit (at_limit)
    );

    always #5 clk = ~clk;

    // Monitor: one expected entry per observation point.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or mid_ev);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (q !== e.q) begin
                    n_fail++;
                    $display("FAIL %s q: got %0d expected %0d (t=%0t)", e.name, q, e.q, $time);
                end
                n_checks++;
                if (tick !== e.tick) begin
                    n_fail++;
                    $display("FAIL %s tick: got %b expected %b (t=%0t)", e.name, tick, e.tick, $time);
                end
                n_checks++;
                if (tc !== e.tc) begin
                    n_fail++;
                    $display("FAIL %s tc: got %b expected %b (t=%0t)", e.name, tc, e.tc, $time);
                end
            end
        end
    end

    task automatic push(input logic [c_WIDTH-1:0] eq, input logic et, input logic ec,
                        input string nm);
        exp_t e;
        e.q = eq; e.tick = et; e.tc = ec; e.name = nm;
        sb.push_back(e);
    endtask

    // Inputs are already set for this cycle; expectation holds at its negedge.
    task automatic cyc(input logic [c_WIDTH-1:0] eq, input logic et, input logic ec,
                       input string nm);
        push(eq, et, ec, nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_b = 1'b0; run = 1'b0; sel = 2'd0; clear_b = 1'b1;
        parload = 1'b0; d = '0;     up = 1'b1;  wrap = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cyc(4'd0, 1'b0, 1'b0, "reset");

        // Reload 0: step every clock, wrap 9 -> 0 with tc one cycle later.
        reset_b = 1'b1; run = 1'b1;
        cyc(4'd0, 1'b1, 1'b0, "first_tick");
        for (int k = 1; k <= 9; k++) cyc(c_WIDTH'(k), 1'b1, 1'b0, "count_up");
        cyc(4'd0, 1'b1, 1'b1, "wrap_tc");
        cyc(4'd1, 1'b1, 1'b0, "after_wrap");

        // Period 4, then a mid-period switch to period 2.
        sel = 2'd3;
        cyc(4'd2, 1'b0, 1'b0, "sel_change_suppress");
        repeat (3) cyc(4'd2, 1'b0, 1'b0, "sel3_wait");
        cyc(4'd2, 1'b1, 1'b0, "sel3_tick");
        repeat (3) cyc(4'd3, 1'b0, 1'b0, "sel3_wait2");
        cyc(4'd3, 1'b1, 1'b0, "sel3_tick2");
        cyc(4'd4, 1'b0, 1'b0, "sel3_mid");
        sel = 2'd1;
        cyc(4'd4, 1'b0, 1'b0, "sel_switch");
        cyc(4'd4, 1'b0, 1'b0, "sel1_wait");
        cyc(4'd4, 1'b1, 1'b0, "sel1_tick");
        cyc(4'd5, 1'b0, 1'b0, "sel1_wait2");
        cyc(4'd5, 1'b1, 1'b0, "sel1_tick2");

        // Saturating count down from a loaded 2.
        sel = 2'd0; parload = 1'b1; d = 4'd2; up = 1'b0; wrap = 1'b0;
        cyc(4'd6, 1'b0, 1'b0, "load2");
        parload = 1'b0;
        cyc(4'd2, 1'b1, 1'b0, "down2");
        cyc(4'd1, 1'b1, 1'b0, "down1");
        cyc(4'd0, 1'b1, 1'b0, "down0");
        cyc(4'd0, 1'b1, 1'b1, "sat0_a");
        cyc(4'd0, 1'b1, 1'b1, "sat0_b");

        // Load clamp, then clear beats load and restarts the divider.
        parload = 1'b1; d = 4'hF;
        cyc(4'd0, 1'b1, 1'b1, "load_f");
        parload = 1'b0; sel = 2'd2;
        cyc(4'd9, 1'b0, 1'b0, "clamped9");
        cyc(4'd9, 1'b0, 1'b0, "sel2_wait");
        clear_b = 1'b0; parload = 1'b1; d = 4'd5;
        cyc(4'd9, 1'b0, 1'b0, "clear_and_load");
        clear_b = 1'b1; parload = 1'b0;
        cyc(4'd0, 1'b0, 1'b0, "cleared_div_reloaded");
        cyc(4'd0, 1'b0, 1'b0, "div_wait");
        up = 1'b1;
        cyc(4'd0, 1'b1, 1'b0, "div_tick");
        cyc(4'd1, 1'b0, 1'b0, "pre_freeze_a");
        cyc(4'd1, 1'b0, 1'b0, "pre_freeze_b");

        // Freeze with the divider at zero.
        run = 1'b0;
        repeat (10) cyc(4'd1, 1'b0, 1'b0, "frozen");
        run = 1'b1;
        cyc(4'd1, 1'b1, 1'b0, "resume_tick");
        cyc(4'd2, 1'b0, 1'b0, "resume_a");
        cyc(4'd2, 1'b0, 1'b0, "resume_b");
        cyc(4'd2, 1'b1, 1'b0, "resume_tick2");

        // Saturate at 9 counting up, then reset between clock edges.
        parload = 1'b1; d = 4'hF; wrap = 1'b0;
        cyc(4'd3, 1'b0, 1'b0, "load_f_up");
        parload = 1'b0;
        cyc(4'd9, 1'b0, 1'b0, "sat9_wait");
        cyc(4'd9, 1'b1, 1'b0, "sat9_tick");
        push(4'd9, 1'b0, 1'b1, "sat9_tc");
        @(negedge clk);
        #1;
        reset_b = 1'b0;
        #2;
        push(4'd0, 1'b0, 1'b0, "async_reset");
        ->mid_ev;
        @(posedge clk);
        #1;
        cyc(4'd0, 1'b0, 1'b0, "reset_hold");

        repeat (3) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time %0t reached expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
